// File: rtl/instr_prefetch_unit_pkg.sv
// Shared types and constants for the instruction prefetch unit.
// Entries carry the fetched word together with its PC.
package instr_prefetch_unit_pkg;

  localparam int          XLEN         = 32;
  localparam logic [31:0] PC_INC       = 32'd4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } pf_entry_t;

  function automatic logic [XLEN-1:0] align_pc(
    input logic [XLEN-1:0] pc
  );
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_prefetch_unit_pf_fifo.sv
// Synchronous FIFO of {pc, instr} entries for the prefetch unit.
// Flush empties the queue and overrides any push or pop that cycle.
module pf_fifo
  import instr_prefetch_unit_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  pf_entry_t     push_data,
  input  logic          pop,
  input  logic          flush,
  output pf_entry_t     rd_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  pf_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] wr_ptr_d;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] rd_ptr_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/instr_prefetch_unit.sv
// Sequential instruction prefetcher with credit-limited requests,
// in-order response tracking and redirect flush with stale discard.
module instr_prefetch_unit
  import instr_prefetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        proto_err
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc_q;
  logic [31:0]   fetch_pc_d;
  logic [31:0]   rsp_pc_q;
  logic [31:0]   rsp_pc_d;
  logic [CW-1:0] outst_q;
  logic [CW-1:0] outst_d;
  logic [CW-1:0] discard_q;
  logic [CW-1:0] discard_d;
  logic          proto_err_q;
  logic          proto_err_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  pf_entry_t     fifo_head;
  pf_entry_t     push_entry;

  logic [CW:0]   used;
  logic          credit_ok;
  logic          req_fire;
  logic          rsp_live;
  logic          rsp_err;
  logic          drop;
  logic          push;
  logic          pop;

  // Every outstanding request holds a FIFO slot in reserve.
  assign used      = {1'b0, fifo_count} + {1'b0, outst_q};
  assign credit_ok = used < (CW+1)'(DEPTH);

  assign imem_req_valid = credit_ok & ~redirect_valid & ~rst;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign rsp_live = imem_rsp_valid & (outst_q != '0);
  assign rsp_err  = imem_rsp_valid & (outst_q == '0);
  assign drop     = (discard_q != '0) | redirect_valid;
  assign push     = rsp_live & ~drop & (~fifo_full | pop);

  assign push_entry.pc    = rsp_pc_q;
  assign push_entry.instr = imem_rsp_data;

  assign out_valid = ~fifo_empty & ~rst;
  assign out_instr = fifo_head.instr;
  assign out_pc    = fifo_head.pc;
  assign pop       = out_valid & out_ready;
  assign proto_err = proto_err_q;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    rsp_pc_d    = rsp_pc_q;
    discard_d   = discard_q;
    proto_err_d = proto_err_q | rsp_err;
    outst_d     = outst_q + CW'(req_fire) - CW'(rsp_live);
    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + PC_INC;
    end
    if (push) begin
      rsp_pc_d = rsp_pc_q + PC_INC;
    end
    if (rsp_live && (discard_q != '0)) begin
      discard_d = discard_q - 1'b1;
    end
    // Whatever is still in flight after this cycle belongs to the old stream.
    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
      rsp_pc_d   = align_pc(redirect_pc);
      discard_d  = outst_q - CW'(rsp_live);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      outst_q     <= '0;
      discard_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      outst_q     <= outst_d;
      discard_q   <= discard_d;
      proto_err_q <= proto_err_d;
    end
  end

  pf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .rd_data   (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Bench for instr_prefetch_unit: in-order memory model with random
// latency, and an expected-stream scoreboard checked by a monitor.
module tb_instr_prefetch_unit;
  import instr_prefetch_unit_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        proto_err;

  instr_prefetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .proto_err      (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int          n_checks = 0;
  int          n_fails  = 0;
  mreq_t       mem_q[$];
  pf_entry_t   sb_q[$];
  logic [31:0] sb_next;
  logic [31:0] exp_req_addr;
  int          cyc = 0;
  int          last_due = 0;
  int          tb_out = 0;
  int          hs_count = 0;
  int          first_hs = -1;
  int          first_ov = -1;
  bit          coinc_hit;

  int          lat_min = 1;
  int          lat_max = 1;
  int          req_rdy_pct = 100;
  bit          ctl_rst = 1'b1;
  bit          ctl_ready = 1'b1;
  bit          ctl_redir = 1'b0;
  logic [31:0] ctl_rpc = '0;
  bit          ctl_inject = 1'b0;
  bit          ctl_coinc = 1'b0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus: inputs change on the falling edge.
  task automatic cycle();
    int          d;
    int          out_pre;
    pf_entry_t   e;
    @(negedge clk);
    cyc++;
    rst            = ctl_rst;
    out_ready      = ctl_ready;
    imem_req_ready = ($urandom_range(99) < req_rdy_pct);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    out_pre        = tb_out;
    if (ctl_rst) begin
      mem_q.delete();
    end else if (ctl_inject) begin
      imem_rsp_valid = 1'b1;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(mem_q[0].addr);
      void'(mem_q.pop_front());
      tb_out--;
    end
    redirect_valid = ctl_redir;
    redirect_pc    = ctl_rpc;
    if (ctl_coinc && !ctl_rst && imem_rsp_valid && out_valid && out_ready) begin
      redirect_valid = 1'b1;
      coinc_hit      = 1'b1;
    end
    #1;
    if (rst) begin
      check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    end else begin
      if (redirect_valid)
        check("req_on_redirect", {31'b0, imem_req_valid}, 32'd0);
      if (imem_req_valid)
        check("credit_limit", {31'b0, out_pre < DEPTH}, 32'd1);
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, exp_req_addr);
        exp_req_addr += 32'd4;
        d = cyc + int'($urandom_range(lat_max, lat_min));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        mem_q.push_back('{addr: imem_req_addr, due: d});
        tb_out++;
        hs_count++;
        if (first_hs < 0) first_hs = cyc;
      end
      if (out_valid && first_ov < 0) first_ov = cyc;
    end
    #2;
    if (rst) begin
      sb_q.delete();
      sb_next      = 32'h0;
      exp_req_addr = 32'h0;
      tb_out       = 0;
      last_due     = 0;
    end else if (redirect_valid) begin
      sb_q.delete();
      sb_next      = {redirect_pc[31:2], 2'b00};
      exp_req_addr = sb_next;
    end
    while (sb_q.size() < 16) begin
      e.pc    = sb_next;
      e.instr = word_of(sb_next);
      sb_q.push_back(e);
      sb_next += 32'd4;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Monitor: each accepted output must be the next word of the live stream.
  always @(negedge clk) begin
    pf_entry_t e;
    #2;
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("out_pc", out_pc, e.pc);
        check("out_instr", out_instr, e.instr);
      end
    end
  end

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    out_ready      = 1'b0;

    // Zero-wait memory, always-ready core.
    ctl_rst = 1'b1;
    run(3);
    ctl_rst  = 1'b0;
    first_hs = -1;
    first_ov = -1;
    run(20);
    check("proto_err_idle", {31'b0, proto_err}, 32'd0);
    check("first_out_latency", 32'(first_ov - first_hs), 32'd2);

    // Stalled core: credit caps requests at DEPTH.
    ctl_rst = 1'b1;
    run(2);
    ctl_rst   = 1'b0;
    ctl_ready = 1'b0;
    hs_count  = 0;
    run(12);
    check("stall_req_count", 32'(hs_count), 32'd4);
    check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    ctl_ready = 1'b1;
    cycle();
    ctl_ready = 1'b0;
    run(6);
    check("one_pop_one_req", 32'(hs_count), 32'd5);
    check("next_fetch_addr", exp_req_addr, 32'h14);
    ctl_ready = 1'b1;
    run(10);

    // Three-cycle memory, redirect with requests in flight.
    lat_min = 3;
    lat_max = 3;
    run(10);
    ctl_redir = 1'b1;
    ctl_rpc   = 32'h100;
    cycle();
    ctl_redir = 1'b0;
    run(25);

    // Misaligned redirect coincident with response and output handshake.
    lat_min   = 1;
    lat_max   = 2;
    ctl_rpc   = 32'h203;
    coinc_hit = 1'b0;
    ctl_coinc = 1'b1;
    for (int i = 0; i < 200 && !coinc_hit; i++) cycle();
    ctl_coinc = 1'b0;
    check("coinc_found", {31'b0, coinc_hit}, 32'd1);
    @(posedge clk);
    #1;
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    check("resume_addr", exp_req_addr, 32'h200);
    run(20);

    // Address wrap at the top of the address space.
    ctl_redir = 1'b1;
    ctl_rpc   = 32'hFFFF_FFF0;
    cycle();
    ctl_redir = 1'b0;
    run(25);
    check("wrap_addr", {31'b0, exp_req_addr < 32'h100}, 32'd1);

    // Spurious response with nothing outstanding.
    lat_min = 1;
    lat_max = 1;
    ctl_rst = 1'b1;
    run(2);
    ctl_rst   = 1'b0;
    ctl_ready = 1'b0;
    run(10);
    check("pre_err_clear", {31'b0, proto_err}, 32'd0);
    ctl_inject = 1'b1;
    cycle();
    ctl_inject = 1'b0;
    @(posedge clk);
    #1;
    check("proto_err_set", {31'b0, proto_err}, 32'd1);
    run(5);
    check("proto_err_sticky", {31'b0, proto_err}, 32'd1);
    ctl_ready = 1'b1;
    run(10);
    ctl_rst = 1'b1;
    cycle();
    @(posedge clk);
    #1;
    check("proto_err_reset", {31'b0, proto_err}, 32'd0);
    ctl_rst = 1'b0;

    // Randomised traffic with redirects and occasional resets.
    lat_min     = 1;
    lat_max     = 4;
    req_rdy_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      ctl_ready = ($urandom_range(99) < 70);
      ctl_redir = ($urandom_range(99) < 3);
      ctl_rst   = ($urandom_range(999) < 3);
      if ($urandom_range(3) == 0)
        ctl_rpc = 32'hFFFF_FFE0 | 32'($urandom_range(31));
      else
        ctl_rpc = $urandom;
      cycle();
    end
    ctl_rst   = 1'b0;
    ctl_redir = 1'b0;
    ctl_ready = 1'b1;
    run(20);
    check("proto_err_random", {31'b0, proto_err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
